// File: rtl/pmcc_pkg.sv
// Shared types and constants for the pixel matrix controller core (PMCC).
package pmcc_pkg;

  localparam int PMCC_PC_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pmcc_fetch_state_t;

  typedef logic [PMCC_PC_W-1:0] pmcc_pc_t;

endpackage

// File: rtl/pmcc_fetch.sv
// PMCC instruction fetch: drives the code RAM address, realigns the registered
// read data with its PC, and handles stall (skid hold), jump, start and halt.
module pmcc_fetch
  import pmcc_pkg::*;
#(
  parameter int PC_W = PMCC_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] pc_if,
  input  logic [31:0]     instr,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            jump_valid,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  output logic            busy,
  output logic [15:0]     fetch_cnt
);

  pmcc_fetch_state_t r_state, w_state_next;
  logic [PC_W-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [PC_W-1:0]   r_resp_pc, w_resp_pc_next;
  logic              r_resp_valid, w_resp_valid_next;
  logic [31:0]       r_hold_instr, w_hold_instr_next;
  logic              r_hold_valid, w_hold_valid_next;
  logic [15:0]       r_fetch_cnt, w_fetch_cnt_next;
  logic              w_instr_valid;
  logic              w_accept;

  assign w_instr_valid = r_resp_valid && (r_state == RUN);
  assign w_accept      = w_instr_valid && !stall && !halt && !jump_valid;

  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_resp_pc_next    = r_resp_pc;
    w_resp_valid_next = r_resp_valid;
    w_hold_instr_next = r_hold_instr;
    w_hold_valid_next = r_hold_valid;
    w_fetch_cnt_next  = r_fetch_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_fetch_pc_next   = start_pc;
          w_resp_valid_next = 1'b0;
          w_hold_valid_next = 1'b0;
          w_fetch_cnt_next  = 16'd0;
          w_state_next      = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          w_state_next      = IDLE;
          w_resp_valid_next = 1'b0;
          w_hold_valid_next = 1'b0;
        end else if (jump_valid && w_instr_valid) begin
          // The read already in flight is on the wrong path; drop it.
          w_fetch_pc_next   = jump_target;
          w_resp_valid_next = 1'b0;
          w_hold_valid_next = 1'b0;
        end else if (stall && w_instr_valid) begin
          // Capture only on the first stalled cycle; later RAM data is for fetch_pc.
          if (!r_hold_valid) begin
            w_hold_instr_next = instr;
            w_hold_valid_next = 1'b1;
          end
        end else begin
          w_resp_pc_next    = r_fetch_pc;
          w_resp_valid_next = 1'b1;
          w_fetch_pc_next   = r_fetch_pc + PC_W'(1);
          w_hold_valid_next = 1'b0;
        end
        if (w_accept && (r_fetch_cnt != 16'hFFFF)) begin
          w_fetch_cnt_next = r_fetch_cnt + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_fetch_pc   <= '0;
      r_resp_pc    <= '0;
      r_resp_valid <= 1'b0;
      r_hold_instr <= 32'd0;
      r_hold_valid <= 1'b0;
      r_fetch_cnt  <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_resp_pc    <= w_resp_pc_next;
      r_resp_valid <= w_resp_valid_next;
      r_hold_instr <= w_hold_instr_next;
      r_hold_valid <= w_hold_valid_next;
      r_fetch_cnt  <= w_fetch_cnt_next;
    end
  end

  assign pc_if       = r_fetch_pc;
  assign instr_o     = r_hold_valid ? r_hold_instr : instr;
  assign pc_o        = r_resp_pc;
  assign instr_valid = w_instr_valid;
  assign busy        = (r_state == RUN);
  assign fetch_cnt   = r_fetch_cnt;

endmodule

// File: doc/pmcc_fetch.md
# pmcc_fetch

Instruction fetch stage of the pixel matrix controller core (PMCC). It drives the word address `pc_if` into the code RAM's instruction port and re-aligns the 1-cycle registered read data with its program counter. It hands instructions to decode/execute with a valid flag and handles stall (with a skid hold register), jump redirect, start and halt.

## Interface
- `PC_W`, default 10: word-address width; the code RAM holds 2^PC_W 32-bit words.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins fetching at `start_pc`. Honoured only in IDLE.
- `start_pc`  in  PC_W  first fetch address.
- `pc_if`  out  PC_W  code RAM read word address; registered, equal to `fetch_pc`.
- `instr`  in  32  code RAM read data for the `pc_if` presented in the previous cycle.
- `instr_o`  out  32  instruction to decode.
- `pc_o`  out  PC_W  address of `instr_o`.
- `instr_valid`  out  1  `instr_o`/`pc_o` are valid.
- `stall`  in  1  decode/execute cannot accept `instr_o` this cycle.
- `jump_valid`  in  1  redirect fetch to `jump_target`. Sampled only when `instr_valid`=1.
- `jump_target`  in  PC_W  redirect address.
- `halt`  in  1  stop fetching and return to IDLE.
- `busy`  out  1  state == RUN.
- `fetch_cnt`  out  16  number of instructions accepted since the last start; saturating.

## Operation
- States: IDLE and RUN.
- Registers: `fetch_pc`, `resp_pc`, `resp_valid`, `hold_instr`, `hold_valid`, `fetch_cnt`, `state`.
- IDLE + `start`:
  - `fetch_pc`<=`start_pc`, `resp_valid`<=0, `hold_valid`<=0, `fetch_cnt`<=0, state<=RUN.
- RUN, evaluated in this priority order:
  1. `halt`: state<=IDLE, `resp_valid`<=0, `hold_valid`<=0. `fetch_pc` is held.
  2. `jump_valid` && `instr_valid`: `fetch_pc`<=`jump_target`, `resp_valid`<=0, `hold_valid`<=0. The wrong-path read is discarded. Jump overrides `stall`.
  3. `stall` && `instr_valid`: `fetch_pc`/`resp_pc` are held. If `hold_valid`=0, then `hold_instr`<=`instr` and `hold_valid`<=1.
  4. Otherwise (advance): `resp_pc`<=`fetch_pc`, `resp_valid`<=1, `fetch_pc`<=`fetch_pc`+1, `hold_valid`<=0.
- PC arithmetic is modulo 2^PC_W: address 1023 wraps to 0.
- Outputs:
  - `instr_o` = `hold_valid` ? `hold_instr` : `instr`.
  - `pc_o` = `resp_pc`.
  - `instr_valid` = `resp_valid` && state==RUN.
- Counter: `fetch_cnt` increments when `instr_valid` && !`stall` && !`halt` && !`jump_valid`. The jump instruction itself therefore does not count. The counter saturates at 16'hFFFF.
- `start` in RUN is ignored.
- `jump_valid`/`stall` with `instr_valid`=0 are ignored, and the bubble advances.

## Timing
- Reset values: state IDLE, `pc_if`=0, `pc_o`=0, `instr_valid`=0, `instr_o`=`instr` passthrough (`hold_valid`=0), `busy`=0, `fetch_cnt`=0.
- Start latency: start pulse at cycle c → `pc_if`=`start_pc` at c+1 → `instr_valid`=1 with `pc_o`=`start_pc` at c+2.
- Sequential fetch: one instruction per cycle with no bubbles.
- Jump penalty: one bubble. A jump at cycle c gives `instr_valid`=0 at c+1, then `pc_o`=`jump_target` valid at c+2.
- Stall of N cycles: `instr_o`/`pc_o` are stable for N+1 cycles. The next instruction follows on the cycle after `stall` drops, with no bubble.
- Halt at cycle c: `instr_valid`=0 and `busy`=0 from c+1.
- Asynchronous reset mid-RUN: all registers go immediately to their reset values, and any pending stall/jump is lost.

## Structure
- `pmcc_pkg` holds:
  - `PMCC_PC_W`=10.
  - `pmcc_fetch_state_t` enum {IDLE, RUN}.
  - `pmcc_pc_t` typedef.
- Single flat module with no sub-modules. The hold/skid register is small enough to remain inline.

## Test plan
- **Start/sequential:** `start_pc`=0x010 with RAM words = address.
  - `pc_o` must be 0x010, 0x011, 0x012… on consecutive cycles from c+2, with `instr_o`=`pc_o` on each.
- **Wrap-around:** `start_pc`=0x3FE.
  - `pc_o` must be 0x3FE, 0x3FF, 0x000, 0x001.
- **Stall:** assert `stall` for 3 cycles while `pc_o`=0x012.
  - `instr_o`=0x012 must be held for 4 cycles.
  - Then 0x013 must follow immediately.
  - `fetch_cnt` increments once for 0x012.
- **Jump:** `jump_valid` with target 0x200 while `pc_o`=0x015.
  - The next cycle must have `instr_valid`=0.
  - The cycle after that must have `pc_o`=0x200.
  - Repeat with `stall`=1 in the same cycle; the jump must still win.
- **Halt/restart:** `halt` while `pc_o`=0x020.
  - `busy`=0 and `instr_valid`=0 next cycle.
  - A new start at 0x005 must reset `fetch_cnt` to 0 and fetch 0x005 two cycles later.
- **Reset mid-run:** assert `rst_n`=0 during a stall.
  - All outputs go to their reset values immediately, and `hold_valid` is cleared.
